// File: rtl/io_bus_responder.sv
// IO-bus responder: LEDs, debounced switch-input channel, seven-segment output channel.
// Define IO_CYCLE_COUNTER_EN to build the free-running cycle counter at 0x14.

module io_debounce #(
    parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    logic [1:0]  sync;
    logic        level;
    logic [19:0] cnt;

    // The level flips only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == DB_CYCLES - 20'd1) begin
                    level <= ~level;
                    cnt   <= '0;
                    rise  <= ~level;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module io_bus_responder #(
    parameter logic [19:0] DB_CYCLES   = 20'd1000000,
    parameter logic [16:0] SCAN_CYCLES = 17'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn_in,
    input  logic        btn_out,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg
);
    localparam int NUM_BTN = 2;

    logic [NUM_BTN-1:0] btn_v, rise;
    logic               in_vld, out_rdy;
    logic [15:0]        in_data;
    logic [31:0]        seg_data;
    logic [16:0]        scan_cnt;
    logic [2:0]         digit;
    logic [3:0]         nib;

    // Index 0 commits the switch input, index 1 acknowledges the display.
    assign btn_v = {btn_out, btn_in};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk (clk),
            .rst (rst),
            .btn (btn_v[i]),
            .rise(rise[i])
        );
    end

    wire wr_led = io_we && (io_addr == 8'h00);
    wire wr_vld = io_we && (io_addr == 8'h04);
    wire wr_seg = io_we && (io_addr == 8'h10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led      <= '0;
            in_vld   <= 1'b0;
            in_data  <= '0;
            out_rdy  <= 1'b1;
            seg_data <= '0;
        end else begin
            if (wr_led)
                led <= io_dout[15:0];
            if (wr_vld)
                in_vld <= 1'b0;
            // A clear in the same cycle frees the slot for the new capture.
            if (rise[0] && (!in_vld || wr_vld)) begin
                in_vld  <= 1'b1;
                in_data <= sw;
            end
            if (wr_seg) begin
                seg_data <= io_dout;
                out_rdy  <= 1'b0;
            end else if (rise[1]) begin
                out_rdy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_CYCLES - 17'd1) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 17'd1;
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cycle;
    wire         wr_cyc = io_we && (io_addr == 8'h14);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cycle <= '0;
        else if (wr_cyc) cycle <= '0;
        else             cycle <= cycle + 32'd1;
    end
`endif

    always_comb begin
        io_din = '0;
        case (io_addr)
            8'h00: io_din = {16'b0, led};
            8'h04: io_din = {31'b0, in_vld};
            8'h08: io_din = {16'b0, in_data};
            8'h0C: io_din = {31'b0, out_rdy};
            8'h10: io_din = seg_data;
`ifdef IO_CYCLE_COUNTER_EN
            8'h14: io_din = cycle;
`endif
            default: io_din = '0;
        endcase
    end

    assign an  = ~(8'b1 << digit);
    assign nib = seg_data[{digit, 2'b00} +: 4];

    always_comb begin
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O responder on the CPU's IO bus: the peripheral end that decodes `io_addr`/`io_we`/`io_dout` writes and returns `io_din` read data. It owns the board LEDs, a debounced switch-input channel with a valid flag, a seven-segment output channel with a ready flag, and a cycle counter. It sits beside the CPU in the top level and is selected whenever the CPU's data address has bit 10 set.

## Interface
- `DB_CYCLES`, 20'd1000000: consecutive stable cycles required by each button debouncer.
- `SCAN_CYCLES`, 17'd100000: cycles each seven-segment digit stays lit.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `io_addr` in 8: byte address within the IO region.
- `io_dout` in 32: write data from the CPU.
- `io_we` in 1: write strobe, sampled on `clk` rising edge.
- `io_din` out 32: read data, combinational from `io_addr`.
- `sw` in 16: board switches, asynchronous.
- `btn_in` in 1: "commit input" button, asynchronous, active-high.
- `btn_out` in 1: "acknowledge output" button, asynchronous, active-high.
- `led` out 16: LED register.
- `an` out 8: digit anodes, active-low one-hot.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Address map, full 8-bit compare; any other address reads 0, writes are ignored:
  - 0x00 LED, R/W: write `led <= io_dout[15:0]`; read `{16'b0, led}`.
  - 0x04 IN_VLD, R/W: read `{31'b0, in_vld}`; any write clears `in_vld`.
  - 0x08 IN_DATA, R: `{16'b0, in_data}`.
  - 0x0C OUT_RDY, R: `{31'b0, out_rdy}`.
  - 0x10 SEG_DATA, R/W: write `seg_data <= io_dout`, `out_rdy <= 0`; read `seg_data`.
  - 0x14 CYCLE, R/W: read `cycle`; any write clears it to 0.
- Reads have no side effects, because the CPU has no read strobe. Handshakes are cleared by writes only.
- Each button passes through a 2-flop synchronizer and then a debouncer:
  - A counter increments while the synchronized level differs from the debounced level and resets to 0 otherwise.
  - When the counter reaches `DB_CYCLES-1`, the debounced level toggles and the counter clears.
  - A debounced 0→1 transition produces a one-cycle pulse.
- Input channel: on a `btn_in` pulse, capture occurs if `in_vld==0` or if this cycle carries a write to 0x04. Capture sets `in_data <= sw` and `in_vld <= 1`. A pulse arriving while `in_vld==1` with no clear is discarded and `in_data` is held.
- Output channel: a `btn_out` pulse sets `out_rdy <= 1`.
  - A write to 0x10 in the same cycle wins, so `out_rdy` stays 0.
  - Writes to 0x10 while `out_rdy==0` are still accepted (overwrite), and `out_rdy` stays 0.
- Scanner:
  - `scan_cnt` counts 0..`SCAN_CYCLES-1`. On wrap, `digit` increments 0..7 and wraps 7→0.
  - `an = ~(8'b1 << digit)`.
  - `seg` is the hex decode of `seg_data[4*digit+3 -: 4]`: 0→7'b1000000, 1→7'b1111001, …, F→7'b0001110.
- `cycle` increments by 1 every cycle and wraps 0xFFFFFFFF→0. A write to 0x14 takes priority over the increment.

## Timing
- Reset values:
  - `led`=0, `in_vld`=0, `in_data`=0, `out_rdy`=1, `seg_data`=0, `cycle`=0.
  - Debouncer levels and counters are 0; `digit`=0 and `scan_cnt`=0.
  - Resulting outputs: `an`=8'hFE, `seg`=7'b1000000, `io_din`=0 for the current address (and `out_rdy` read as 1 at 0x0C).
- Reset asserted mid-operation returns all state to these values immediately. Any in-progress debounce is lost.
- Read latency is 0 cycles, so `io_din` is valid in the same cycle as `io_addr`.
- Write effect is visible on a read in the cycle after the `io_we` edge.
- Button-to-flag latency, for a clean step: 2 synchronizer cycles + `DB_CYCLES` + 1 capture cycle.
- A glitch shorter than `DB_CYCLES` cycles produces no pulse.
- The button pulse is exactly 1 cycle wide per press. A release followed by another press requires `DB_CYCLES` cycles of stable low in between.

## Configuration
- `IO_CYCLE_COUNTER_EN` defined: the 32-bit `cycle` register and address 0x14 exist as specified.
- `IO_CYCLE_COUNTER_EN` undefined: no counter is built, 0x14 reads 0, and writes to 0x14 are ignored.

## Test plan
All scenarios use `DB_CYCLES`=4 and `SCAN_CYCLES`=3.
- Reset, then read each address: 0x0C→1, every other address→0, `an`=FE, `seg`=40h (7'b1000000).
- Write 0x00 with 0xDEADBEEF, then read 0x00 → 0x0000BEEF, `led`=BEEF; read 0x18 and 0x01 → 0.
- `sw`=0x1234, hold `btn_in` high for 6 cycles → `in_vld`=1 within 7 cycles and 0x08 reads 0x1234.
  - Change `sw`=0x5678 and press again → 0x08 still reads 0x1234.
  - Write 0x04 in the same cycle as the next pulse → `in_vld`=1 and 0x08 reads 0x5678.
- `btn_in` glitch of 3 high cycles → `in_vld` stays 0.
- Write 0x10 with 0x89ABCDEF → `out_rdy`=0.
  - Over 24 cycles `an` steps FE,FD,…,7F, each held for 3 cycles, with `seg` = decode of F,E,D,…,8.
  - `btn_out` pulse coinciding with a write to 0x10 → `out_rdy` stays 0; a later lone pulse → `out_rdy`=1.
- With the macro defined: read 0x14 twice, 5 cycles apart → difference 5; write 0x14 → next read 1. Without the macro: 0x14 always reads 0.
